reg_file_wb: RTL and testbench

- Integer register file plus write-back stage of the multi-cycle RV32I core.
- Directly upstream of the ALU: registered read ports drive ALU_srcA/ALU_srcB.
- Directly downstream of the ALU: accepts ALU_resp, load data or PC+4, extends and aligns it, and commits it to the destination register.

---
 rtl/reg_file_wb_if.sv | 35 +++
 rtl/reg_file_wb.sv | 119 +++++++++++
 tb/tb_reg_file_wb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_file_wb_if.sv
// Operand-read and write-back bus between the RV32I control/ALU and the
// register file. Master drives requests, the register file is the slave.
interface reg_file_wb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rd_data1;
  logic [XLEN-1:0]   rd_data2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [1:0]        wb_sel;
  logic [XLEN-1:0]   ALU_resp;
  logic [XLEN-1:0]   load_data;
  logic [2:0]        load_funct3;
  logic [1:0]        load_byte_off;
  logic [XLEN-1:0]   pc;
  logic              wb_done;
  logic              wb_err;
  logic [XLEN-1:0]   wb_value;

  modport master (
    output rd_en, rs1_addr, rs2_addr, wb_en, wb_addr, wb_sel, ALU_resp,
           load_data, load_funct3, load_byte_off, pc,
    input  rd_data1, rd_data2, wb_done, wb_err, wb_value
  );

  modport slave (
    input  rd_en, rs1_addr, rs2_addr, wb_en, wb_addr, wb_sel, ALU_resp,
           load_data, load_funct3, load_byte_off, pc,
    output rd_data1, rd_data2, wb_done, wb_err, wb_value
  );
endinterface

// File: rtl/reg_file_wb.sv
// RV32I integer register file with registered read ports and a write-back
// stage that selects, extends and commits ALU / load / link values.
module reg_file_wb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_wb_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic              ok;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   value;
  } wb_req_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  logic            ld_err;
  logic [XLEN-1:0] sel_val;
  logic            sel_err;
  wb_req_t         wb;
  logic [XLEN-1:0] nxt_rd1, nxt_rd2;

  // Load extraction: byte lane by offset, halfword by offset[1].
  always_comb begin
    ld_byte = bus.load_data[{bus.load_byte_off, 3'b000} +: 8];
    ld_half = bus.load_byte_off[1] ? bus.load_data[31:16] : bus.load_data[15:0];
    ld_val  = '0;
    ld_err  = 1'b0;
    case (bus.load_funct3)
      3'b000: ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_err = bus.load_byte_off[0];
      end
      3'b101: begin
        ld_val = {{(XLEN-16){1'b0}}, ld_half};
        ld_err = bus.load_byte_off[0];
      end
      3'b010: begin
        ld_val = bus.load_data;
        ld_err = (bus.load_byte_off != 2'b00);
      end
      default: ld_err = 1'b1;
    endcase
  end

  always_comb begin
    sel_val = '0;
    sel_err = 1'b0;
    case (wb_sel_e'(bus.wb_sel))
      SEL_ALU:  sel_val = bus.ALU_resp;
      SEL_LOAD: begin
        sel_val = ld_val;
        sel_err = ld_err;
      end
      SEL_PC4:  sel_val = bus.pc + XLEN'(4);
      SEL_RSVD: sel_err = 1'b1;
      default:  sel_err = 1'b1;
    endcase
  end

  always_comb begin
    wb.ok    = bus.wb_en && !sel_err;
    wb.err   = bus.wb_en && sel_err;
    wb.addr  = bus.wb_addr;
    wb.value = (bus.wb_addr == '0) ? '0 : sel_val;
  end

  // Same-edge bypass: a committing write to a nonzero register wins over the
  // stale array contents; x0 writes carry value 0 so they fall out naturally.
  always_comb begin
    nxt_rd1 = (bus.rs1_addr == '0) ? '0 : regs[bus.rs1_addr];
    nxt_rd2 = (bus.rs2_addr == '0) ? '0 : regs[bus.rs2_addr];
    if (wb.ok && wb.addr != '0 && wb.addr == bus.rs1_addr) nxt_rd1 = wb.value;
    if (wb.ok && wb.addr != '0 && wb.addr == bus.rs2_addr) nxt_rd2 = wb.value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb.ok && wb.addr != '0) begin
      regs[wb.addr] <= wb.value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data1 <= '0;
      bus.rd_data2 <= '0;
      bus.wb_done  <= 1'b0;
      bus.wb_err   <= 1'b0;
      bus.wb_value <= '0;
    end else begin
      if (bus.rd_en) begin
        bus.rd_data1 <= nxt_rd1;
        bus.rd_data2 <= nxt_rd2;
      end
      bus.wb_done <= wb.ok;
      bus.wb_err  <= wb.err;
      if (wb.ok) bus.wb_value <= wb.value;
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed, table-driven bench for reg_file_wb: one vector per clock edge,
// plus hand-written reset sequences.
module tb_reg_file_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_file_wb_if #(.XLEN(32), .ADDR_W(5)) bus ();

  reg_file_wb #(.XLEN(32), .NREGS(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wb_en;
    logic [4:0]  wa;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] pc;
    logic        rd_en;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_done;
    logic        e_err;
    logic [31:0] e_val;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];
  localparam logic [31:0] LD = 32'h80FF7F01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_sel = 0; bus.ALU_resp = 0;
    bus.load_data = LD; bus.load_funct3 = 3'b010; bus.load_byte_off = 0; bus.pc = 0;
  endtask

  task automatic add(input string n, input logic we, input logic [4:0] wa,
                     input logic [1:0] sel, input logic [31:0] alu,
                     input logic [2:0] f3, input logic [1:0] off, input logic [31:0] pc,
                     input logic re, input logic [4:0] r1, input logic [4:0] r2,
                     input logic d, input logic e, input logic [31:0] v,
                     input logic [31:0] d1, input logic [31:0] d2);
    vec_t t;
    t.name = n; t.wb_en = we; t.wa = wa; t.sel = sel; t.alu = alu; t.f3 = f3;
    t.off = off; t.pc = pc; t.rd_en = re; t.r1 = r1; t.r2 = r2;
    t.e_done = d; t.e_err = e; t.e_val = v; t.e_d1 = d1; t.e_d2 = d2;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string n, input logic d, input logic e,
                            input logic [31:0] v, input logic [31:0] d1, input logic [31:0] d2);
    chk({n, ".wb_done"},  32'(bus.wb_done), 32'(d));
    chk({n, ".wb_err"},   32'(bus.wb_err),  32'(e));
    chk({n, ".wb_value"}, bus.wb_value, v);
    chk({n, ".rd_data1"}, bus.rd_data1, d1);
    chk({n, ".rd_data2"}, bus.rd_data2, d2);
  endtask

  initial begin
    //   name      we wa  sel   alu           f3    off pc            re r1  r2  done err value         rd1           rd2
    add("alu_x7",  1, 7,  2'b00, 32'hDEADBEEF, 3'd0, 0, 32'h0,        0, 0,  0,  1,  0, 32'hDEADBEEF, 32'h0,        32'h0);
    add("rd_x7",   0, 0,  2'b00, 32'h0,        3'd0, 0, 32'h0,        1, 7,  0,  0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    add("lb_off3", 1, 8,  2'b01, 32'h0,        3'd0, 3, 32'h0,        1, 8,  7,  1,  0, 32'hFFFFFF80, 32'hFFFFFF80, 32'hDEADBEEF);
    add("lbu_off1",1, 9,  2'b01, 32'h0,        3'd4, 1, 32'h0,        1, 9,  8,  1,  0, 32'h0000007F, 32'h0000007F, 32'hFFFFFF80);
    add("lh_off2", 1, 10, 2'b01, 32'h0,        3'd1, 2, 32'h0,        1, 10, 10, 1,  0, 32'hFFFF80FF, 32'hFFFF80FF, 32'hFFFF80FF);
    add("lhu_off0",1, 11, 2'b01, 32'h0,        3'd5, 0, 32'h0,        1, 11, 9,  1,  0, 32'h00007F01, 32'h00007F01, 32'h0000007F);
    add("lw_off0", 1, 12, 2'b01, 32'h0,        3'd2, 0, 32'h0,        1, 12, 11, 1,  0, 32'h80FF7F01, 32'h80FF7F01, 32'h00007F01);
    add("lh_off1", 1, 12, 2'b01, 32'h0,        3'd1, 1, 32'h0,        1, 12, 0,  0,  1, 32'h80FF7F01, 32'h80FF7F01, 32'h0);
    add("lw_off2", 1, 11, 2'b01, 32'h0,        3'd2, 2, 32'h0,        1, 11, 12, 0,  1, 32'h80FF7F01, 32'h00007F01, 32'h80FF7F01);
    add("f3_011",  1, 10, 2'b01, 32'h0,        3'd3, 0, 32'h0,        1, 10, 10, 0,  1, 32'h80FF7F01, 32'hFFFF80FF, 32'hFFFF80FF);
    add("sel_11",  1, 9,  2'b11, 32'h12345678, 3'd2, 0, 32'h0,        1, 9,  9,  0,  1, 32'h80FF7F01, 32'h0000007F, 32'h0000007F);
    add("jal_wrap",1, 7,  2'b10, 32'h0,        3'd0, 0, 32'hFFFFFFFC, 1, 7,  8,  1,  0, 32'h0,        32'h0,        32'hFFFFFF80);
    add("jal_pc4", 1, 13, 2'b10, 32'h0,        3'd0, 0, 32'h00001000, 1, 13, 7,  1,  0, 32'h00001004, 32'h00001004, 32'h0);
    add("byp_x3",  1, 3,  2'b00, 32'hA5A5A5A5, 3'd0, 0, 32'h0,        1, 3,  3,  1,  0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    add("hold_wr", 1, 3,  2'b00, 32'h00000001, 3'd0, 0, 32'h0,        0, 3,  3,  1,  0, 32'h00000001, 32'hA5A5A5A5, 32'hA5A5A5A5);
    add("hold_id", 0, 0,  2'b00, 32'h0,        3'd0, 0, 32'h0,        0, 3,  0,  0,  0, 32'h00000001, 32'hA5A5A5A5, 32'hA5A5A5A5);
    add("rd_x3",   0, 0,  2'b00, 32'h0,        3'd0, 0, 32'h0,        1, 3,  0,  0,  0, 32'h00000001, 32'h00000001, 32'h0);
    add("wr_x0",   1, 0,  2'b00, 32'hFFFFFFFF, 3'd0, 0, 32'h0,        1, 0,  0,  1,  0, 32'h0,        32'h0,        32'h0);
    add("rd_x3_x0",0, 0,  2'b00, 32'h0,        3'd0, 0, 32'h0,        1, 3,  0,  0,  0, 32'h0,        32'h00000001, 32'h0);

    idle();
    #12;
    check_outs("rst_state", 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.wb_en = vecs[i].wb_en; bus.wb_addr = vecs[i].wa; bus.wb_sel = vecs[i].sel;
      bus.ALU_resp = vecs[i].alu; bus.load_funct3 = vecs[i].f3;
      bus.load_byte_off = vecs[i].off; bus.pc = vecs[i].pc;
      bus.rd_en = vecs[i].rd_en; bus.rs1_addr = vecs[i].r1; bus.rs2_addr = vecs[i].r2;
      @(posedge clk); #1;
      check_outs(vecs[i].name, vecs[i].e_done, vecs[i].e_err, vecs[i].e_val,
                 vecs[i].e_d1, vecs[i].e_d2);
    end

    // Reset between edges: write x5 then pull rst_n low mid-cycle.
    @(negedge clk);
    idle();
    bus.wb_en = 1; bus.wb_addr = 5; bus.ALU_resp = 32'h1234;
    bus.rd_en = 1; bus.rs1_addr = 5; bus.rs2_addr = 5;
    @(posedge clk); #1;
    check_outs("pre_rst", 1, 0, 32'h1234, 32'h1234, 32'h1234);
    #2;
    idle();
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 0, 0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_outs("rst_held", 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_en = 1; bus.rs1_addr = 5; bus.rs2_addr = 3;
    @(posedge clk); #1;
    check_outs("post_rst_x5_x3", 0, 0, 32'h0, 32'h0, 32'h0);

    // Rejected write to a register being read must not bypass.
    @(negedge clk);
    bus.wb_en = 1; bus.wb_addr = 5; bus.wb_sel = 2'b11; bus.ALU_resp = 32'hCAFE;
    bus.rs1_addr = 5; bus.rs2_addr = 0;
    @(posedge clk); #1;
    check_outs("err_no_byp", 0, 1, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check_outs("err_clear", 0, 0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
